// File: rtl/gpmc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpmc_pkg
//  Description : Shared constants and state encoding for the synchronous
//                GPMC initiator.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpmc_pkg;

    // Width of the multiplexed address/data bus.
    localparam int AD_WIDTH = 16;

    // Width of the per-phase tick counter (covers WRITE_TICKS/READ_LATENCY up to 255).
    localparam int CNT_WIDTH = 8;

    // Idle level of every active-low GPMC strobe.
    localparam logic CTRL_INACTIVE = 1'b1;

    // Bus cycle states.
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_ADDR  = 3'd1;
    localparam state_t S_WDATA = 3'd2;
    localparam state_t S_RDATA = 3'd3;
    localparam state_t S_END   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/gpmc_sync_master.sv
`default_nettype none
// ============================================================================
//  Module      : gpmc_sync_master
//  Description : Synchronous GPMC initiator issuing single-beat multiplexed
//                address/data reads and writes from a req/ack user port.
//                gpmc_clk = clk/2; all bus outputs are registered and only
//                change on the clk edge where gpmc_clk rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpmc_sync_master
    import gpmc_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int WRITE_TICKS  = 1,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  gpmc_clk,
    output logic                  gpmc_csn,
    output logic                  gpmc_advn,
    output logic                  gpmc_oen,
    output logic                  gpmc_wen,
    output logic [AD_WIDTH-1:0]   gpmc_ad_out,
    output logic                  gpmc_ad_oe,
    input  logic [AD_WIDTH-1:0]   gpmc_ad_in
);

    localparam logic [CNT_WIDTH-1:0] WR_LAST = CNT_WIDTH'(WRITE_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] RD_LAST = CNT_WIDTH'(READ_LATENCY - 1);

    logic                  gclk_q;
    logic                  busy_q;
    logic                  ack_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  csn_q, advn_q, oen_q, wen_q, ad_oe_q;
    logic [AD_WIDTH-1:0]   ad_out_q;

    // gpmc_clk is low before a rise tick and high before a fall edge.
    logic w_rise, w_fall, w_accept, w_enter_end;
    assign w_rise      = ~gclk_q;
    assign w_fall      = gclk_q;
    assign w_accept    = ~busy_q & req;
    assign w_enter_end = w_rise && (state_d == S_END) && (state_q != S_END);

    // Next-state and tick-counter logic; the FSM only advances on rise ticks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (w_rise) begin
            case (state_q)
                S_IDLE:  if (busy_q) state_d = S_ADDR;
                S_ADDR: begin
                    state_d = we_q ? S_WDATA : S_RDATA;
                    cnt_d   = '0;
                end
                S_WDATA: begin
                    if (cnt_q == WR_LAST) state_d = S_END;
                    else                  cnt_d   = cnt_q + 1'b1;
                end
                S_RDATA: begin
                    if (cnt_q == RD_LAST) state_d = S_END;
                    else                  cnt_d   = cnt_q + 1'b1;
                end
                // busy_q set here means a request was accepted during END.
                S_END:   state_d = busy_q ? S_ADDR : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Clock divider, FSM state and tick counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gclk_q  <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            gclk_q  <= ~gclk_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // User port: request capture, busy flag and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            ack_q <= w_enter_end;
            if (w_accept) begin
                busy_q  <= 1'b1;
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end else if (w_enter_end) begin
                busy_q  <= 1'b0;
            end
        end
    end

    // Read data is sampled on the fall edge of the last read tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (w_fall && (state_q == S_RDATA) && (cnt_q == RD_LAST)) begin
            rdata_q <= DATA_WIDTH'(gpmc_ad_in);
        end
    end

    // Registered bus outputs decoded from the state being entered, so every
    // strobe is glitch-free and only moves on rise ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csn_q    <= CTRL_INACTIVE;
            advn_q   <= CTRL_INACTIVE;
            oen_q    <= CTRL_INACTIVE;
            wen_q    <= CTRL_INACTIVE;
            ad_oe_q  <= 1'b0;
            ad_out_q <= '0;
        end else if (w_rise) begin
            csn_q    <= CTRL_INACTIVE;
            advn_q   <= CTRL_INACTIVE;
            oen_q    <= CTRL_INACTIVE;
            wen_q    <= CTRL_INACTIVE;
            ad_oe_q  <= 1'b0;
            ad_out_q <= '0;
            case (state_d)
                S_ADDR: begin
                    csn_q    <= ~CTRL_INACTIVE;
                    advn_q   <= ~CTRL_INACTIVE;
                    ad_oe_q  <= 1'b1;
                    ad_out_q <= AD_WIDTH'(addr_q);
                end
                S_WDATA: begin
                    csn_q    <= ~CTRL_INACTIVE;
                    wen_q    <= ~CTRL_INACTIVE;
                    ad_oe_q  <= 1'b1;
                    ad_out_q <= AD_WIDTH'(wdata_q);
                end
                // Bus released from the first read tick for turnaround.
                S_RDATA: begin
                    csn_q    <= ~CTRL_INACTIVE;
                    oen_q    <= ~CTRL_INACTIVE;
                end
                default: ;
            endcase
        end
    end

    assign busy        = busy_q;
    assign ack         = ack_q;
    assign rdata       = rdata_q;
    assign gpmc_clk    = gclk_q;
    assign gpmc_csn    = csn_q;
    assign gpmc_advn   = advn_q;
    assign gpmc_oen    = oen_q;
    assign gpmc_wen    = wen_q;
    assign gpmc_ad_oe  = ad_oe_q;
    assign gpmc_ad_out = ad_out_q;

endmodule
`default_nettype wire

// File: tb/tb_gpmc_sync_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_gpmc_sync_master
//  Description : Self-checking bench for gpmc_sync_master with a behavioural
//                GPMC target memory and a per-tick bus trace.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpmc_sync_master;

    localparam int WT = 1;
    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        busy, ack;
    logic [15:0] rdata;
    logic        gpmc_clk, gpmc_csn, gpmc_advn, gpmc_oen, gpmc_wen, gpmc_ad_oe;
    logic [15:0] gpmc_ad_out, gpmc_ad_in;

    int vectors = 0;
    int errors  = 0;

    gpmc_sync_master #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .WRITE_TICKS(WT), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy), .ack(ack), .rdata(rdata),
        .gpmc_clk(gpmc_clk), .gpmc_csn(gpmc_csn), .gpmc_advn(gpmc_advn),
        .gpmc_oen(gpmc_oen), .gpmc_wen(gpmc_wen), .gpmc_ad_out(gpmc_ad_out),
        .gpmc_ad_oe(gpmc_ad_oe), .gpmc_ad_in(gpmc_ad_in)
    );

    always #5 clk = ~clk;

    // Behavioural GPMC target: latches address and write data on gpmc_clk falls.
    logic [15:0] tmem [0:65535];
    logic [15:0] taddr = '0;
    assign gpmc_ad_in = (!gpmc_csn && !gpmc_oen) ? tmem[taddr] : 16'h0000;
    always @(negedge gpmc_clk) begin
        if (!gpmc_csn && !gpmc_advn) taddr <= gpmc_ad_out;
        if (!gpmc_csn && !gpmc_wen && gpmc_ad_oe) tmem[taddr] <= gpmc_ad_out;
    end

    // Per-tick trace of the bus plus protocol watchdog.
    typedef struct packed {
        logic        csn, advn, oen, wen, oe;
        logic [15:0] ad;
    } tick_t;
    tick_t tlog[$];
    tick_t exp_q[$];
    tick_t snap, prev_snap;
    int    ack_cnt = 0;
    int    viol = 0;
    assign snap = '{gpmc_csn, gpmc_advn, gpmc_oen, gpmc_wen, gpmc_ad_oe, gpmc_ad_out};

    always @(negedge clk) begin
        if (rst_n) begin
            if (gpmc_clk) tlog.push_back(snap);
            if (ack) ack_cnt <= ack_cnt + 1;
            if (!gpmc_oen && !gpmc_wen) begin
                viol <= viol + 1;
                $display("FAIL protocol_oen_wen at %0t: both low", $time);
            end
            if (!gpmc_oen && gpmc_ad_oe) begin
                viol <= viol + 1;
                $display("FAIL protocol_contention at %0t: ad_oe=1 with oen=0", $time);
            end
            if (!gpmc_clk && snap != prev_snap) begin
                viol <= viol + 1;
                $display("FAIL protocol_fall_change at %0t: got %h was %h", $time, snap, prev_snap);
            end
        end
        prev_snap <= snap;
    end

    function automatic tick_t mk(input logic c, a, o, w, e, input logic [15:0] d);
        tick_t t;
        t = '{c, a, o, w, e, d};
        return t;
    endfunction

    // Expected tick sequence of one transaction derived from the bus rules.
    function automatic void push_shape(input logic w, input logic [15:0] a, input logic [15:0] d);
        exp_q.push_back(mk(0, 0, 1, 1, 1, a));
        if (w) for (int k = 0; k < WT; k++) exp_q.push_back(mk(0, 1, 1, 0, 1, d));
        else   for (int k = 0; k < RL; k++) exp_q.push_back(mk(0, 1, 0, 1, 0, 16'h0));
        exp_q.push_back(mk(1, 1, 1, 1, 0, 16'h0));
    endfunction

    // Index of the first trace tick that departs from exp_q (-1 none, -2 no cycle seen).
    function automatic int shape_err(output tick_t got, output tick_t want);
        int s;
        s = -1;
        got = '0;
        want = '0;
        foreach (tlog[i]) if (s < 0 && tlog[i].csn == 1'b0) s = i;
        if (s < 0) return -2;
        foreach (exp_q[k]) begin
            want = exp_q[k];
            if (s + k >= tlog.size()) begin got = '1; return k; end
            got = tlog[s + k];
            if (got[20:16] !== want[20:16] || (want.oe && got.ad !== want.ad)) return k;
        end
        return -1;
    endfunction

    // Issues one transaction; returns clk edges from accept to ack.
    task automatic do_txn(input logic w, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output int lat, output bit ok,
                          output logic ack_next);
        @(posedge clk); #1;
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 0;
        ok = 1'b0;
        while (lat < 40 && !ok) begin
            @(posedge clk); #1;
            lat++;
            if (ack) ok = 1'b1;
        end
        rd = rdata;
        @(posedge clk); #1;
        ack_next = ack;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({gpmc_clk, gpmc_csn, gpmc_advn, gpmc_oen, gpmc_wen, gpmc_ad_oe, busy, ack} !== 8'b0111_1000
            || gpmc_ad_out !== 16'h0 || rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: got clk/csn/advn/oen/wen/oe/busy/ack=%b ad=%h rdata=%h want 01111000 0000 0000",
                     {gpmc_clk, gpmc_csn, gpmc_advn, gpmc_oen, gpmc_wen, gpmc_ad_oe, busy, ack}, gpmc_ad_out, rdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic check_txn(input string nm, input logic w, input logic [15:0] a, input logic [15:0] d,
                             input logic [15:0] rd, input int lat, input bit ok, input logic ack_next,
                             input logic [15:0] exp_rd);
        tick_t got, want;
        int e, lo, hi;
        lo = 2 * (2 + (w ? WT : RL)) - 1;
        hi = lo + 2;
        vectors++;
        if (!ok) begin errors++; $display("FAIL %s_ack: no ack within 40 clk", nm); end
        vectors++;
        if (lat < lo || lat > hi) begin errors++; $display("FAIL %s_latency: got %0d want %0d..%0d", nm, lat, lo, hi); end
        vectors++;
        if (ack_next !== 1'b0) begin errors++; $display("FAIL %s_ack_width: ack still %b next clk want 0", nm, ack_next); end
        exp_q = {};
        push_shape(w, a, d);
        e = shape_err(got, want);
        vectors++;
        if (e != -1) begin errors++; $display("FAIL %s_shape: tick %0d got %h want %h", nm, e, got, want); end
        vectors++;
        if (!w && rd !== exp_rd) begin errors++; $display("FAIL %s_rdata: got %h want %h", nm, rd, exp_rd); end
        if (w && tmem[a] !== d) begin errors++; $display("FAIL %s_target_mem: got %h want %h", nm, tmem[a], d); end
    endtask

    task automatic test_write();
        logic [15:0] rd; int lat; bit ok; logic an;
        tlog = {};
        do_txn(1'b1, 16'h1234, 16'hBEEF, rd, lat, ok, an);
        check_txn("write", 1'b1, 16'h1234, 16'hBEEF, rd, lat, ok, an, 16'h0);
    endtask

    task automatic test_read();
        logic [15:0] rd; int lat; bit ok; logic an;
        tmem[16'h0042] = 16'hA5A5;
        tlog = {};
        do_txn(1'b0, 16'h0042, 16'h0000, rd, lat, ok, an);
        check_txn("read", 1'b0, 16'h0042, 16'h0000, rd, lat, ok, an, 16'hA5A5);
    endtask

    task automatic test_reset_mid_read();
        int n, acks0;
        logic [15:0] rd; int lat; bit ok; logic an;
        tmem[16'h0100] = 16'h5555;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 16'h0100;
        @(posedge clk); #1;
        req = 1'b0;
        n = 0;
        while (gpmc_oen !== 1'b0 && n < 20) begin @(posedge clk); #1; n++; end
        vectors++;
        if (gpmc_oen !== 1'b0) begin errors++; $display("FAIL midreset_reach_rdata: oen=%b want 0", gpmc_oen); end
        acks0 = ack_cnt;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({gpmc_clk, gpmc_csn, gpmc_advn, gpmc_oen, gpmc_wen, gpmc_ad_oe, busy, ack} !== 8'b0111_1000
            || rdata !== 16'h0) begin
            errors++;
            $display("FAIL midreset_state: got %b rdata=%h want 01111000 0000",
                     {gpmc_clk, gpmc_csn, gpmc_advn, gpmc_oen, gpmc_wen, gpmc_ad_oe, busy, ack}, rdata);
        end
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_hold: ack=%b busy=%b want 0 0", ack, busy); end
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if (ack_cnt != acks0) begin errors++; $display("FAIL midreset_no_ack: acks got %0d want %0d", ack_cnt, acks0); end
        tlog = {};
        do_txn(1'b0, 16'h0100, 16'h0000, rd, lat, ok, an);
        check_txn("post_reset_read", 1'b0, 16'h0100, 16'h0000, rd, lat, ok, an, 16'h5555);
    endtask

    task automatic test_back_to_back();
        tick_t got, want;
        int n, e;
        logic [15:0] rd;
        tmem[16'h0777] = 16'hC0DE;
        tlog = {};
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 16'h0555; wdata = 16'h1357;
        @(posedge clk); #1;
        we = 1'b0; addr = 16'h0777; wdata = 16'h0000;
        n = 0;
        while (!ack && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: busy=%b want 1", busy); end
        req = 1'b0;
        n = 0;
        while (!ack && n < 40) begin @(posedge clk); #1; n++; end
        rd = rdata;
        @(negedge clk); #1;
        vectors++;
        if (rd !== 16'hC0DE) begin errors++; $display("FAIL b2b_rdata: got %h want c0de", rd); end
        vectors++;
        if (tmem[16'h0555] !== 16'h1357) begin errors++; $display("FAIL b2b_write: got %h want 1357", tmem[16'h0555]); end
        exp_q = {};
        push_shape(1'b1, 16'h0555, 16'h1357);
        push_shape(1'b0, 16'h0777, 16'h0000);
        e = shape_err(got, want);
        vectors++;
        if (e != -1) begin errors++; $display("FAIL b2b_shape: tick %0d got %h want %h", e, got, want); end
    endtask

    task automatic test_busy_ignore();
        int acks0, addr_ticks;
        logic [15:0] seen;
        tmem[16'h0001] = 16'h1111;
        acks0 = ack_cnt;
        tlog = {};
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 16'h0002; wdata = 16'h2222;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req = 1'b1; we = 1'b1; addr = 16'h0001; wdata = 16'h9999;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk); #1;
        addr_ticks = 0;
        seen = 16'hFFFF;
        foreach (tlog[i]) if (!tlog[i].csn && !tlog[i].advn) begin addr_ticks++; seen = tlog[i].ad; end
        vectors++;
        if (ack_cnt - acks0 != 1) begin errors++; $display("FAIL busy_ignore_acks: got %0d want 1", ack_cnt - acks0); end
        vectors++;
        if (addr_ticks != 1 || seen !== 16'h0002) begin
            errors++;
            $display("FAIL busy_ignore_addr: addr ticks %0d last %h want 1 0002", addr_ticks, seen);
        end
        vectors++;
        if (tmem[16'h0001] !== 16'h1111 || tmem[16'h0002] !== 16'h2222) begin
            errors++;
            $display("FAIL busy_ignore_mem: [1]=%h [2]=%h want 1111 2222", tmem[16'h0001], tmem[16'h0002]);
        end
    endtask

    task automatic test_scoreboard();
        logic [15:0] sa [64];
        logic [15:0] sd [64];
        logic [15:0] rd;
        int unsigned r;
        int lat; bit ok; logic an;
        for (int i = 0; i < 64; i++) begin
            r = $urandom;
            sa[i] = {r[9:0], 6'(i)};
            sd[i] = 16'($urandom);
        end
        for (int i = 0; i < 64; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_txn(1'b1, sa[i], sd[i], rd, lat, ok, an);
            vectors++;
            if (!ok || an !== 1'b0) begin errors++; $display("FAIL sb_write_%0d: ok=%0b ack_next=%b", i, ok, an); end
        end
        for (int i = 0; i < 64; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_txn(1'b0, sa[i], 16'h0000, rd, lat, ok, an);
            vectors++;
            if (!ok || rd !== sd[i] || lat < 2 * (2 + RL) - 1 || lat > 2 * (2 + RL) + 1) begin
                errors++;
                $display("FAIL sb_read_%0d: addr %h got %h lat %0d ok %0b want %h", i, sa[i], rd, lat, ok, sd[i]);
            end
        end
    endtask

    task automatic test_protocol();
        vectors++;
        if (viol != 0) begin errors++; $display("FAIL protocol_total: got %0d violations want 0", viol); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) tmem[i] = 16'h0000;
        test_reset();
        test_write();
        test_read();
        test_reset_mid_read();
        test_back_to_back();
        test_busy_ignore();
        test_scoreboard();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
